// File: rtl/lsu_axi_split.sv
// ---------------------------------------------------------------------------
// lsu_axi_split
//
// Load/store unit sitting between EX/MEM and MEM/WB. Takes one request at a
// time over valid/ready and runs it as one or two single-beat AXI4
// transactions. A misaligned access either spans two aligned words
// (SPLIT_EN=1) or is trapped with no bus activity (SPLIT_EN=0). Loads return
// sign/zero-extended data. Stores return a completion. Bus errors and
// misalignment return a precise exception cause.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_*             upstream request (op, byte address, LSB-aligned store
//                     data, size, unsigned flag)
//   resp_*            downstream result (extended load data, exc, cause)
//   m_ar*/m_r*        AXI read address / read data channels
//   m_aw*/m_w*/m_b*   AXI write address / write data / write response
// ---------------------------------------------------------------------------
module lsu_axi_split #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_exc,
    output logic [3:0]          resp_cause,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [2:0]          m_arsize,
    output logic [7:0]          m_arlen,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic                m_rlast,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [2:0]          m_awsize,
    output logic [7:0]          m_awlen,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic                m_wlast,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    typedef enum logic [2:0] {IDLE, ISSUE, R_WAIT, W_WAIT, B_WAIT, SEND} state_t;

    state_t              state_q, state_d;
    logic                is_load_q, is_load_d;
    logic                is_store_q, is_store_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic                two_beats_q, two_beats_d;
    logic                beat_q, beat_d;
    logic [DATA_W-1:0]   merged_q, merged_d;
    logic                exc_q, exc_d;
    logic [3:0]          cause_q, cause_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    logic [OFF_W-1:0]    off;
    logic [OFF_W+3:0]    hi_shift;
    logic [3:0]          q_bytes;
    logic [3:0]          in_bytes;
    logic                in_misaligned;
    logic                in_two_beats;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W-1:0]   beat_addr;
    logic [2*BYTES-1:0]  strb_full;
    logic [DATA_W-1:0]   ext_mask;
    logic                ext_sign;
    logic [DATA_W-1:0]   ext_data;
    logic                unused_rlast;

    // Every transaction is a single beat, so rlast carries no information.
    assign unused_rlast = m_rlast;

    assign m_arsize = 3'(OFF_W);
    assign m_awsize = 3'(OFF_W);
    assign m_arlen  = 8'd0;
    assign m_awlen  = 8'd0;
    assign m_wlast  = 1'b1;

    // Address/data shaping for the current beat of the latched request.
    // The byte-strobe is built over two words so the overflow into the
    // second beat falls out of the upper half.
    always_comb begin
        off       = addr_q[OFF_W-1:0];
        q_bytes   = 4'd1 << size_q;
        hi_shift  = (OFF_W+4)'((BYTES - int'(off)) * 8);
        base_addr = addr_q & ~ADDR_W'(BYTES - 1);
        beat_addr = beat_q ? base_addr + ADDR_W'(BYTES) : base_addr;
        strb_full = '0;
        for (int i = 0; i < 2 * BYTES; i++) begin
            strb_full[i] = (i >= int'(off)) && (i < int'(off) + int'(q_bytes));
        end
        m_araddr = beat_addr;
        m_awaddr = beat_addr;
        m_wdata  = beat_q ? (wdata_q >> hi_shift) : (wdata_q << {off, 3'b000});
        m_wstrb  = beat_q ? strb_full[2*BYTES-1:BYTES] : strb_full[BYTES-1:0];
    end

    // Decode of the incoming request, used only while IDLE accepts it.
    always_comb begin
        in_bytes      = 4'd1 << req_size;
        in_misaligned = (req_addr[2:0] & 3'(in_bytes - 4'd1)) != 3'd0;
        in_two_beats  = (int'(req_addr[OFF_W-1:0]) + int'(in_bytes)) > BYTES;
    end

    // Sign/zero extension of the merged load bytes to the full data width.
    always_comb begin
        ext_mask = '0;
        ext_sign = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < 8 * int'(q_bytes)) begin
                ext_mask[i] = 1'b1;
            end
            if (i == 8 * int'(q_bytes) - 1) begin
                ext_sign = merged_q[i];
            end
        end
        ext_data = merged_q & ext_mask;
        if (!unsigned_q && ext_sign) begin
            ext_data = ext_data | ~ext_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            two_beats_q <= 1'b0;
            beat_q      <= 1'b0;
            merged_q    <= '0;
            exc_q       <= 1'b0;
            cause_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_load_q   <= is_load_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            two_beats_q <= two_beats_d;
            beat_q      <= beat_d;
            merged_q    <= merged_d;
            exc_q       <= exc_d;
            cause_q     <= cause_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_load_d   = is_load_q;
        is_store_d  = is_store_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        two_beats_d = two_beats_q;
        beat_d      = beat_q;
        merged_d    = merged_q;
        exc_d       = exc_q;
        cause_d     = cause_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        resp_exc    = 1'b0;
        resp_cause  = '0;
        m_arvalid   = 1'b0;
        m_rready    = 1'b0;
        m_awvalid   = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    is_load_d   = (req_op == 2'b01);
                    is_store_d  = (req_op == 2'b10);
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    size_d      = req_size;
                    unsigned_d  = req_unsigned;
                    two_beats_d = 1'b0;
                    beat_d      = 1'b0;
                    merged_d    = '0;
                    exc_d       = 1'b0;
                    cause_d     = 4'd0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    if (req_op != 2'b01 && req_op != 2'b10) begin
                        state_d = SEND;
                    end else if (in_misaligned && SPLIT_EN == 0) begin
                        exc_d   = 1'b1;
                        cause_d = (req_op == 2'b01) ? 4'd4 : 4'd6;
                        state_d = SEND;
                    end else begin
                        two_beats_d = in_two_beats;
                        state_d     = ISSUE;
                    end
                end
            end
            // AW and W complete independently; W_WAIT only ever holds a store.
            ISSUE, W_WAIT: begin
                if (is_load_q) begin
                    m_arvalid = 1'b1;
                    if (m_arready) begin
                        state_d = R_WAIT;
                    end
                end else begin
                    m_awvalid = !aw_done_q;
                    m_wvalid  = !w_done_q;
                    aw_done_d = aw_done_q | m_awready;
                    w_done_d  = w_done_q | m_wready;
                    state_d   = (aw_done_d && w_done_d) ? B_WAIT : W_WAIT;
                end
            end
            // Beat 0 lands bytes [off..] at the bottom; beat 1 fills in above.
            R_WAIT: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    if (m_rresp != 2'b00) begin
                        exc_d   = 1'b1;
                        cause_d = 4'd5;
                        state_d = SEND;
                    end else if (!beat_q) begin
                        merged_d = m_rdata >> {off, 3'b000};
                        if (two_beats_q) begin
                            beat_d  = 1'b1;
                            state_d = ISSUE;
                        end else begin
                            state_d = SEND;
                        end
                    end else begin
                        merged_d = merged_q | (m_rdata << hi_shift);
                        state_d  = SEND;
                    end
                end
            end
            // A completed first store beat stays written even if beat 1 faults.
            B_WAIT: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        exc_d   = 1'b1;
                        cause_d = 4'd7;
                        state_d = SEND;
                    end else if (two_beats_q && !beat_q) begin
                        beat_d    = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                resp_valid = 1'b1;
                resp_exc   = exc_q;
                resp_cause = cause_q;
                resp_rdata = (is_load_q && !exc_q) ? ext_data : '0;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_axi_split.sv
module tb_lsu_axi_split;

    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [3:0]  cause;
        bit          chk_data;
    } resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req_valid, req_ready, req_unsigned;
    logic [1:0]    req_op, req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_ready, resp_exc;
    logic [DW-1:0] resp_rdata;
    logic [3:0]    resp_cause;
    logic [AW-1:0] m_araddr, m_awaddr;
    logic          m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [2:0]    m_arsize, m_awsize;
    logic [7:0]    m_arlen, m_awlen;
    logic [DW-1:0] m_rdata, m_wdata;
    logic [1:0]    m_rresp, m_bresp;
    logic          m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
    logic [3:0]    m_wstrb;
    logic          m_bvalid, m_bready;

    // Second instance with splitting disabled; its slave side never answers.
    logic          n_req_valid, n_req_ready, n_req_unsigned;
    logic [1:0]    n_req_op, n_req_size;
    logic [AW-1:0] n_req_addr;
    logic          n_resp_valid, n_resp_ready, n_resp_exc;
    logic [DW-1:0] n_resp_rdata;
    logic [3:0]    n_resp_cause;
    logic [AW-1:0] n_araddr, n_awaddr;
    logic          n_arvalid, n_rready, n_awvalid, n_wvalid, n_wlast, n_bready;
    logic [2:0]    n_arsize, n_awsize;
    logic [7:0]    n_arlen, n_awlen;
    logic [DW-1:0] n_wdata;
    logic [3:0]    n_wstrb;

    resp_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    ar_count = 0;
    int    n_axi_seen = 0;

    lsu_axi_split #(.DATA_W(DW), .ADDR_W(AW), .SPLIT_EN(1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_exc(resp_exc), .resp_cause(resp_cause),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_arsize(m_arsize), .m_arlen(m_arlen),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_rlast(m_rlast),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_awsize(m_awsize), .m_awlen(m_awlen),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_wlast(m_wlast),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    lsu_axi_split #(.DATA_W(DW), .ADDR_W(AW), .SPLIT_EN(0)) u_dut_nosplit (
        .clk(clk), .reset(reset),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_op(n_req_op),
        .req_addr(n_req_addr), .req_wdata(32'h0000_5A5A), .req_size(n_req_size),
        .req_unsigned(n_req_unsigned),
        .resp_valid(n_resp_valid), .resp_ready(n_resp_ready),
        .resp_rdata(n_resp_rdata), .resp_exc(n_resp_exc), .resp_cause(n_resp_cause),
        .m_araddr(n_araddr), .m_arvalid(n_arvalid), .m_arready(1'b0),
        .m_arsize(n_arsize), .m_arlen(n_arlen),
        .m_rdata(32'h0), .m_rresp(2'b00), .m_rvalid(1'b0),
        .m_rready(n_rready), .m_rlast(1'b0),
        .m_awaddr(n_awaddr), .m_awvalid(n_awvalid), .m_awready(1'b0),
        .m_awsize(n_awsize), .m_awlen(n_awlen),
        .m_wdata(n_wdata), .m_wstrb(n_wstrb), .m_wvalid(n_wvalid),
        .m_wready(1'b0), .m_wlast(n_wlast),
        .m_bresp(2'b00), .m_bvalid(1'b0), .m_bready(n_bready)
    );

    // Count AR handshakes on the splitting unit and any bus request from the
    // trapping unit, so absence of traffic can be checked afterwards.
    always @(posedge clk) begin
        if (m_arvalid && m_arready) ar_count++;
        if (n_arvalid || n_awvalid || n_wvalid) n_axi_seen++;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request (entered at a negedge) and queues its expected response.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns,
                                 input logic [31:0] wdata, input logic [31:0] er,
                                 input logic ee, input logic [3:0] ec, input bit cd);
        resp_t e;
        int    k = 0;
        e.rdata = er; e.exc = ee; e.cause = ec; e.chk_data = cd;
        exp_q.push_back(e);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        chk("req_ready_wait", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0; req_op = 2'b00;
        @(negedge clk);
    endtask

    // Waits for a response, compares it against the scoreboard head, retires it.
    task automatic checkOutput(input string tag, output int waited);
        resp_t e;
        waited = 0;
        while (!resp_valid && waited < 50) begin @(negedge clk); waited++; end
        chk({tag, "_resp_valid"}, resp_valid, 1'b1);
        chk({tag, "_queue"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk_data) chk({tag, "_rdata"}, resp_rdata, e.rdata);
            chk({tag, "_exc"}, resp_exc, e.exc);
            chk({tag, "_cause"}, resp_cause, e.cause);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_req_ready_after"}, req_ready, 1'b1);
    endtask

    // Zero-wait read slave; rvalid is raised together with arready.
    task automatic serveRead(input string tag, input logic [31:0] exp_addr,
                             input logic [31:0] word, input logic [1:0] resp);
        int k = 0;
        while (!m_arvalid && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_arvalid"}, m_arvalid, 1'b1);
        chk({tag, "_araddr"}, m_araddr, exp_addr);
        m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = word; m_rresp = resp;
        @(posedge clk);
        @(negedge clk);
        m_arready = 1'b0;
        k = 0;
        while (!m_rready && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_rready"}, m_rready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        m_rvalid = 1'b0; m_rresp = 2'b00;
    endtask

    task automatic serveWrite(input string tag, input logic [31:0] exp_addr,
                              input logic [31:0] exp_data, input logic [3:0] exp_strb,
                              input logic [1:0] resp, input bit w_late);
        int k = 0;
        while (!m_awvalid && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_awvalid"}, m_awvalid, 1'b1);
        chk({tag, "_wvalid"}, m_wvalid, 1'b1);
        chk({tag, "_awaddr"}, m_awaddr, exp_addr);
        chk({tag, "_wdata"}, m_wdata, exp_data);
        chk({tag, "_wstrb"}, m_wstrb, exp_strb);
        if (w_late) begin
            m_awready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            m_awready = 1'b0;
            chk({tag, "_aw_dropped_w_held"}, {m_awvalid, m_wvalid}, 2'b01);
            m_wready = 1'b1;
        end else begin
            m_awready = 1'b1; m_wready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        m_awready = 1'b0; m_wready = 1'b0;
        chk({tag, "_valids_low"}, {m_awvalid, m_wvalid}, 2'b00);
        k = 0;
        while (!m_bready && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_bready"}, m_bready, 1'b1);
        m_bvalid = 1'b1; m_bresp = resp;
        @(posedge clk);
        @(negedge clk);
        m_bvalid = 1'b0; m_bresp = 2'b00;
    endtask

    initial begin
        int          waited;
        int          ar_before;
        logic [31:0] t_addr [5];
        logic [1:0]  t_size [5];
        logic        t_uns  [5];
        logic [31:0] t_exp  [5];

        reset = 1'b1;
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; resp_ready = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b0; m_rlast = 1'b1;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        n_req_valid = 1'b0; n_req_op = 2'b00; n_req_addr = '0; n_req_size = 2'd0;
        n_req_unsigned = 1'b0; n_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] reset state");
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_valids", {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, resp_valid}, 6'b0);
        chk("rst_resp", {resp_exc, resp_cause, resp_rdata}, 37'h0);
        chk("rst_size_len", {m_arsize, m_awsize, m_arlen, m_awlen}, {3'd2, 3'd2, 16'h0});

        $display("[TB] signed halfword load, zero-wait latency");
        applyStimulus(2'b01, 32'h8000_0002, 2'd1, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0, 4'd0, 1'b1);
        serveRead("lh", 32'h8000_0000, 32'hBEEF_1234, 2'b00);
        checkOutput("lh", waited);
        chk("lh_latency", waited, 0);

        $display("[TB] extension table");
        t_addr = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0002, 32'h8000_0001, 32'h8000_0000};
        t_size = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
        t_uns  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        t_exp  = '{32'h0000_0012, 32'hFFFF_FFBE, 32'h0000_BEEF, 32'hFFFF_EF12, 32'hBEEF_1234};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b01, t_addr[i], t_size[i], t_uns[i], 32'h0, t_exp[i], 1'b0, 4'd0, 1'b1);
            serveRead("ext", 32'h8000_0000, 32'hBEEF_1234, 2'b00);
            checkOutput("ext", waited);
        end

        $display("[TB] split word load");
        ar_before = ar_count;
        applyStimulus(2'b01, 32'h8000_0003, 2'd2, 1'b0, 32'h0, 32'h7766_5544, 1'b0, 4'd0, 1'b1);
        serveRead("lw_split0", 32'h8000_0000, 32'h4433_2211, 2'b00);
        serveRead("lw_split1", 32'h8000_0004, 32'h8877_6655, 2'b00);
        checkOutput("lw_split", waited);
        chk("lw_split_ar_beats", ar_count - ar_before, 2);

        $display("[TB] split word store");
        applyStimulus(2'b10, 32'h8000_0002, 2'd2, 1'b0, 32'hA1B2_C3D4, 32'h0, 1'b0, 4'd0, 1'b1);
        serveWrite("sw_split0", 32'h8000_0000, 32'hC3D4_0000, 4'b1100, 2'b00, 1'b1);
        serveWrite("sw_split1", 32'h8000_0004, 32'h0000_A1B2, 4'b0011, 2'b00, 1'b0);
        checkOutput("sw_split", waited);

        $display("[TB] bus faults");
        applyStimulus(2'b01, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5, 1'b0);
        serveRead("lw_fault", 32'h8000_0010, 32'hDEAD_BEEF, 2'b10);
        checkOutput("lw_fault", waited);
        ar_before = ar_count;
        applyStimulus(2'b01, 32'h8000_0006, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 4'd5, 1'b0);
        serveRead("lw_split_fault", 32'h8000_0004, 32'hDEAD_BEEF, 2'b10);
        checkOutput("lw_split_fault", waited);
        chk("lw_split_fault_ar_beats", ar_count - ar_before, 1);
        applyStimulus(2'b10, 32'h8000_0008, 2'd1, 1'b0, 32'h0000_5555, 32'h0, 1'b1, 4'd7, 1'b1);
        serveWrite("sh_fault", 32'h8000_0008, 32'h0000_5555, 4'b0011, 2'b10, 1'b0);
        checkOutput("sh_fault", waited);

        $display("[TB] no-op requests");
        applyStimulus(2'b00, 32'h8000_0000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1);
        checkOutput("op_none", waited);
        chk("op_none_latency", waited, 0);
        applyStimulus(2'b11, 32'h8000_0001, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1);
        checkOutput("op_11", waited);

        $display("[TB] misaligned trap with splitting disabled");
        for (int i = 0; i < 2; i++) begin
            n_req_valid = 1'b1;
            n_req_op    = (i == 0) ? 2'b10 : 2'b01;
            n_req_addr  = (i == 0) ? 32'h8000_0001 : 32'h8000_0002;
            n_req_size  = (i == 0) ? 2'd1 : 2'd2;
            @(posedge clk);
            #1 n_req_valid = 1'b0;
            @(negedge clk);
            chk("trap_resp_valid", n_resp_valid, 1'b1);
            chk("trap_exc", n_resp_exc, 1'b1);
            chk("trap_cause", n_resp_cause, (i == 0) ? 4'd6 : 4'd4);
            chk("trap_rdata", n_resp_rdata, 32'h0);
            n_resp_ready = 1'b1;
            @(posedge clk);
            #1 n_resp_ready = 1'b0;
            @(negedge clk);
            chk("trap_req_ready_after", n_req_ready, 1'b1);
        end
        chk("trap_no_axi", n_axi_seen, 0);

        $display("[TB] response stall then reset mid-store");
        applyStimulus(2'b10, 32'h8000_0020, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 4'd0, 1'b1);
        serveWrite("sw_stall", 32'h8000_0020, 32'h1234_5678, 4'b1111, 2'b00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {resp_valid, m_arvalid, m_awvalid, m_wvalid}, 4'b1000);
            @(negedge clk);
        end
        checkOutput("sw_stall", waited);
        applyStimulus(2'b10, 32'h8000_0024, 2'd2, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, 4'd0, 1'b1);
        chk("mid_store_awvalid", m_awvalid, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        chk("post_reset_valids", {resp_valid, m_awvalid, m_wvalid, m_arvalid}, 4'b0000);
        chk("post_reset_req_ready", req_ready, 1'b1);
        m_bvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_bvalid = 1'b0;
        chk("late_b_ignored", {m_bready, resp_valid, req_ready}, 3'b001);

        $display("[TB] recovery load");
        applyStimulus(2'b01, 32'h8000_0040, 2'd2, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0, 4'd0, 1'b1);
        serveRead("lw_recover", 32'h8000_0040, 32'h0BAD_F00D, 2'b00);
        checkOutput("lw_recover", waited);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
